freq_counter_ctrl: RTL and testbench

//  Wishbone-controlled sequencer for the frequency-counter edge datapath. Holds the

---
 rtl/freq_ctrl_pkg.sv | 35 +++
 rtl/gate_window_timer.sv | 36 +++
 rtl/freq_counter_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_freq_counter_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// Shared definitions for the frequency-counter control block: register map,
// CTRL/STATUS bit positions, sequencer states and fixed timing constants.
package freq_ctrl_pkg;

    // Register offsets, selected by wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    // Cycles spent with the gate closed so that the datapath synchroniser
    // has delivered every edge counted inside the window
    localparam int SETTLE_CYCLES = 2;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        GATE    = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4
    } state_t;

endpackage

// File: rtl/gate_window_timer.sv
// Down-counter shared by the GATE and SETTLE phases. It is loaded with the
// phase length and flags the final cycle of that phase when it reaches one.
module gate_window_timer
    import freq_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    input  logic                dec,
    output logic                last
);

    localparam logic [PERIOD_W-1:0] ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] count_r;

    // Load has priority over decrement; the counter never wraps below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == ONE);

endmodule

// File: rtl/freq_counter_ctrl.sv
// Wishbone-controlled sequencer for the frequency-counter edge datapath.
// Holds the measurement configuration, runs clear -> gate -> settle ->
// capture, latches the edge count into RESULT and reports done/overflow.
module freq_counter_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          PERIOD_W  = 16,
    parameter int          COUNT_W   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               dp_clear_o,
    output logic               dp_gate_o,
    input  logic [COUNT_W-1:0] dp_count_i,
    output logic               busy_o,
    output logic               irq_o
);

    localparam logic [PERIOD_W-1:0] PERIOD_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] SETTLE_LOAD = PERIOD_W'(SETTLE_CYCLES);

    // Bus request captured on the hit cycle and committed on the ack cycle
    logic               hit_s;
    logic               accept_s;
    logic               ack_r;
    logic               req_we_r;
    logic [3:0]         req_sel_r;
    logic [1:0]         req_adr_r;
    logic [31:0]        req_dat_r;
    logic [31:0]        dat_r;
    logic [31:0]        rd_mux_s;

    // Register file
    logic               enable_r, cont_r, irq_en_r;
    logic [PERIOD_W-1:0] period_r;
    logic               done_r, ovf_r;
    logic [COUNT_W-1:0] result_r;

    logic               enable_nx_s, cont_nx_s, irq_en_nx_s;
    logic [PERIOD_W-1:0] period_nx_s;
    logic               done_nx_s, ovf_nx_s;
    logic [COUNT_W-1:0] result_nx_s;

    // Write decode
    logic               wr_s, wr_ctrl_s, wr_period_s, wr_status_s;
    logic               en_eff_s, period_nz_s, start_ok_s;

    // Sequencer
    state_t             state_r, state_nx_s;
    logic               tmr_load_s, tmr_dec_s, tmr_last_s, capture_s;
    logic [PERIOD_W-1:0] tmr_load_val_s;
    logic               sat_s;

    // Registered outputs
    logic               clear_r, gate_r, busy_r, irq_r;

    // Address bits below the word boundary and data bits above the widest
    // register carry no information for this block
    logic               adr_unused_s;
    logic               dat_unused_s;

    assign adr_unused_s = ^{wbs_adr_i[1:0], req_dat_r[31:PERIOD_W]};
    assign dat_unused_s = adr_unused_s;

    assign hit_s    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign accept_s = hit_s & ~ack_r;

    assign wr_s        = ack_r & req_we_r & (req_sel_r == 4'hF);
    assign wr_ctrl_s   = wr_s & (req_adr_r == REG_CTRL);
    assign wr_period_s = wr_s & (req_adr_r == REG_PERIOD);
    assign wr_status_s = wr_s & (req_adr_r == REG_STATUS);

    // A CTRL write that clears enable takes effect in the same cycle it lands
    assign en_eff_s    = wr_ctrl_s ? req_dat_r[CTRL_ENABLE] : enable_r;
    assign period_nz_s = (period_r != PERIOD_ZERO);
    assign start_ok_s  = wr_ctrl_s & req_dat_r[CTRL_START] & req_dat_r[CTRL_ENABLE] & period_nz_s;
    assign sat_s       = &dp_count_i;

    // Read multiplexer evaluated on the hit cycle; unused bits read as zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (wbs_adr_i[3:2])
            REG_CTRL: begin
                rd_mux_s[CTRL_ENABLE] = enable_r;
                rd_mux_s[CTRL_CONT]   = cont_r;
                rd_mux_s[CTRL_IRQ_EN] = irq_en_r;
            end
            REG_PERIOD: begin
                rd_mux_s[PERIOD_W-1:0] = period_r;
            end
            REG_STATUS: begin
                rd_mux_s[STAT_BUSY] = busy_r;
                rd_mux_s[STAT_DONE] = done_r;
                rd_mux_s[STAT_OVF]  = ovf_r;
            end
            REG_RESULT: begin
                rd_mux_s[COUNT_W-1:0] = result_r;
            end
            default: begin
                rd_mux_s = 32'd0;
            end
        endcase
    end

    // Single-cycle ack with a guaranteed idle cycle between acks
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_r     <= 1'b0;
            dat_r     <= 32'd0;
            req_we_r  <= 1'b0;
            req_sel_r <= 4'h0;
            req_adr_r <= 2'd0;
            req_dat_r <= 32'd0;
        end else begin
            ack_r <= accept_s;
            dat_r <= (accept_s & ~wbs_we_i) ? rd_mux_s : 32'd0;
            if (accept_s) begin
                req_we_r  <= wbs_we_i;
                req_sel_r <= wbs_sel_i;
                req_adr_r <= wbs_adr_i[3:2];
                req_dat_r <= wbs_dat_i;
            end else begin
                req_we_r  <= 1'b0;
                req_sel_r <= req_sel_r;
                req_adr_r <= req_adr_r;
                req_dat_r <= req_dat_r;
            end
        end
    end

    // Sequencer next state and timer control
    always_comb begin
        state_nx_s     = state_r;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = period_r;
        tmr_dec_s      = 1'b0;
        capture_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nx_s = CLEAR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLEAR: begin
                // PERIOD is sampled here; later writes affect the next window
                tmr_load_s     = 1'b1;
                tmr_load_val_s = period_r;
                if (!en_eff_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = GATE;
                end
            end
            GATE: begin
                if (!en_eff_s) begin
                    state_nx_s = IDLE;
                end else if (tmr_last_s) begin
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = SETTLE_LOAD;
                    state_nx_s     = SETTLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            SETTLE: begin
                if (!en_eff_s) begin
                    state_nx_s = IDLE;
                end else if (tmr_last_s) begin
                    state_nx_s = CAPTURE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            CAPTURE: begin
                if (!en_eff_s) begin
                    state_nx_s = IDLE;
                end else begin
                    capture_s = 1'b1;
                    if (cont_r && period_nz_s) begin
                        state_nx_s = CLEAR;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Register file next values; a capture beats a same-cycle W1C
    always_comb begin
        enable_nx_s = enable_r;
        cont_nx_s   = cont_r;
        irq_en_nx_s = irq_en_r;
        period_nx_s = period_r;
        done_nx_s   = done_r;
        ovf_nx_s    = ovf_r;
        result_nx_s = result_r;
        if (wr_ctrl_s) begin
            enable_nx_s = req_dat_r[CTRL_ENABLE];
            cont_nx_s   = req_dat_r[CTRL_CONT];
            irq_en_nx_s = req_dat_r[CTRL_IRQ_EN];
        end else begin
            enable_nx_s = enable_r;
        end
        if (wr_period_s) begin
            period_nx_s = req_dat_r[PERIOD_W-1:0];
        end else begin
            period_nx_s = period_r;
        end
        if (capture_s) begin
            done_nx_s   = 1'b1;
            result_nx_s = dp_count_i;
        end else if (wr_status_s && req_dat_r[STAT_DONE]) begin
            done_nx_s = 1'b0;
        end else begin
            done_nx_s = done_r;
        end
        if (capture_s && sat_s) begin
            ovf_nx_s = 1'b1;
        end else if (wr_status_s && req_dat_r[STAT_OVF]) begin
            ovf_nx_s = 1'b0;
        end else begin
            ovf_nx_s = ovf_r;
        end
    end

    // State, register file and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r  <= IDLE;
            enable_r <= 1'b0;
            cont_r   <= 1'b0;
            irq_en_r <= 1'b0;
            period_r <= PERIOD_ZERO;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            result_r <= {COUNT_W{1'b0}};
            clear_r  <= 1'b0;
            gate_r   <= 1'b0;
            busy_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            enable_r <= enable_nx_s;
            cont_r   <= cont_nx_s;
            irq_en_r <= irq_en_nx_s;
            period_r <= period_nx_s;
            done_r   <= done_nx_s;
            ovf_r    <= ovf_nx_s;
            result_r <= result_nx_s;
            clear_r  <= (state_nx_s == CLEAR);
            gate_r   <= (state_nx_s == GATE);
            busy_r   <= (state_nx_s != IDLE);
            irq_r    <= irq_en_nx_s & done_nx_s;
        end
    end

    gate_window_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .dec      (tmr_dec_s),
        .last     (tmr_last_s)
    );

    assign wbs_ack_o  = ack_r;
    assign wbs_dat_o  = dat_r;
    assign dp_clear_o = clear_r;
    assign dp_gate_o  = gate_r;
    assign busy_o     = busy_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_freq_counter_ctrl.sv
// Directed bench for freq_counter_ctrl with a simple edge-datapath model
// producing one edge every two gated clocks.
module tb_freq_counter_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dp_clear_o, dp_gate_o, busy_o, irq_o;
    logic [15:0] dp_count_i;

    logic        sat_mode;
    logic [15:0] dp_cnt_r;
    logic        dp_ph_r;
    int          gate_hi_cnt;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] rdat;
    logic        acked;
    int          cyc;
    int          g0;
    int          nclr;
    int          tclr [3];

    always #5 wb_clk_i = ~wb_clk_i;

    freq_counter_ctrl dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .dp_clear_o (dp_clear_o),
        .dp_gate_o  (dp_gate_o),
        .dp_count_i (dp_count_i),
        .busy_o     (busy_o),
        .irq_o      (irq_o)
    );

    // Datapath model: one edge every two gated clocks, saturating
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            dp_cnt_r <= 16'd0;
            dp_ph_r  <= 1'b0;
        end else if (dp_clear_o) begin
            dp_cnt_r <= 16'd0;
            dp_ph_r  <= 1'b0;
        end else if (dp_gate_o) begin
            dp_ph_r <= ~dp_ph_r;
            if (dp_ph_r && (dp_cnt_r != 16'hFFFF)) dp_cnt_r <= dp_cnt_r + 16'd1;
        end
    end

    assign dp_count_i = sat_mode ? 16'hFFFF : dp_cnt_r;

    // Running count of clocks with the gate open
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) gate_hi_cnt <= 0;
        else if (dp_gate_o) gate_hi_cnt <= gate_hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output logic ok);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        ok = 1'b0;
        rd = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                ok = 1'b1;
                rd = wbs_dat_o;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        logic        ok;
        wb_xfer(1'b1, BASE | {28'd0, off, 2'b00}, d, 4'hF, r, ok);
        check("wr_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic reg_rd(input logic [1:0] off, output logic [31:0] d);
        logic ok;
        wb_xfer(1'b0, BASE | {28'd0, off, 2'b00}, 32'd0, 4'hF, d, ok);
        check("rd_ack", {31'd0, ok}, 32'd1);
    endtask

    // Counts edges from the start-commit edge (index 0) until busy drops
    task automatic wait_idle(output int n);
        n = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (i > 0 && !busy_o) begin
                n = i;
                break;
            end
        end
        check("idle_timeout", {31'd0, (n < 0)}, 32'd0);
    endtask

    initial begin
        wb_rst_n  = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_dat_i = 32'd0;
        wbs_adr_i = 32'd0;
        sat_mode  = 1'b0;

        // Reset values
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_ack",   {31'd0, wbs_ack_o},  32'd0);
        check("rst_dat",   wbs_dat_o,           32'd0);
        check("rst_busy",  {31'd0, busy_o},     32'd0);
        check("rst_gate",  {31'd0, dp_gate_o},  32'd0);
        check("rst_clear", {31'd0, dp_clear_o}, 32'd0);
        check("rst_irq",   {31'd0, irq_o},      32'd0);
        wb_rst_n = 1'b1;
        reg_rd(2'd0, rdat); check("rst_ctrl",   rdat, 32'd0);
        reg_rd(2'd1, rdat); check("rst_period", rdat, 32'd0);
        reg_rd(2'd2, rdat); check("rst_status", rdat, 32'd0);
        reg_rd(2'd3, rdat); check("rst_result", rdat, 32'd0);

        // Out-of-window address is never acked
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, rdat, acked);
        check("nohit_ack", {31'd0, acked}, 32'd0);

        // Single window, PERIOD=10, 1 edge per 2 clocks -> 5 edges
        reg_wr(2'd1, 32'd10);
        reg_wr(2'd0, 32'h5);
        g0 = gate_hi_cnt;
        wait_idle(cyc);
        check("lat_p10", cyc, 32'd14);
        check("gate_len_p10", gate_hi_cnt - g0, 32'd10);
        reg_rd(2'd2, rdat); check("status_done", rdat, 32'h2);
        reg_rd(2'd3, rdat); check("result_p10", rdat, 32'd5);
        reg_rd(2'd3, rdat); check("result_reread", rdat, 32'd5);
        reg_rd(2'd0, rdat); check("ctrl_start_sc", rdat, 32'h1);
        reg_wr(2'd2, 32'h2);
        reg_rd(2'd2, rdat); check("status_w1c", rdat, 32'h0);

        // Continuous mode, PERIOD=4 -> clear pulse every 8 cycles
        reg_wr(2'd1, 32'd4);
        reg_wr(2'd0, 32'h7);
        nclr = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge wb_clk_i);
            #1;
            if (dp_clear_o && nclr < 3) begin
                tclr[nclr] = c;
                nclr++;
            end
        end
        check("cont_nclr", nclr, 32'd3);
        check("cont_first", tclr[0], 32'd0);
        check("cont_gap1", tclr[1] - tclr[0], 32'd8);
        check("cont_gap2", tclr[2] - tclr[1], 32'd8);
        reg_wr(2'd0, 32'h0);
        reg_wr(2'd2, 32'h6);
        reg_rd(2'd2, rdat); check("cont_stop_status", rdat, 32'h0);

        // Abort mid-GATE by clearing enable: gate drops, no capture
        reg_wr(2'd0, 32'h7);
        @(posedge wb_clk_i);
        reg_wr(2'd0, 32'h2);
        check("abort_gate_before", {31'd0, dp_gate_o}, 32'd1);
        @(posedge wb_clk_i);
        #1;
        check("abort_gate_after", {31'd0, dp_gate_o}, 32'd0);
        check("abort_busy_after", {31'd0, busy_o}, 32'd0);
        repeat (10) @(posedge wb_clk_i);
        reg_rd(2'd2, rdat); check("abort_status", rdat, 32'h0);

        // Saturated count sets ovf; W1C colliding with capture loses
        sat_mode = 1'b1;
        reg_wr(2'd1, 32'd3);
        reg_wr(2'd0, 32'h5);
        wait_idle(cyc);
        check("lat_p3", cyc, 32'd7);
        reg_rd(2'd2, rdat); check("sat_status", rdat, 32'h6);
        reg_rd(2'd3, rdat); check("sat_result", rdat, 32'hFFFF);
        reg_wr(2'd0, 32'h5);
        repeat (6) @(posedge wb_clk_i);
        reg_wr(2'd2, 32'h6);
        reg_rd(2'd2, rdat); check("collide_status", rdat, 32'h6);
        reg_wr(2'd2, 32'h6);
        reg_rd(2'd2, rdat); check("collide_w1c", rdat, 32'h0);
        sat_mode = 1'b0;

        // Start ignored with PERIOD=0 or enable=0
        reg_wr(2'd1, 32'd0);
        reg_wr(2'd0, 32'h5);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("p0_busy", {31'd0, busy_o}, 32'd0);
        reg_rd(2'd2, rdat); check("p0_status", rdat, 32'h0);
        reg_wr(2'd1, 32'd5);
        reg_wr(2'd0, 32'h4);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("en0_busy", {31'd0, busy_o}, 32'd0);

        // PERIOD write during GATE leaves the running window at 6
        reg_wr(2'd1, 32'd6);
        reg_wr(2'd0, 32'h5);
        g0 = gate_hi_cnt;
        @(posedge wb_clk_i);
        reg_wr(2'd1, 32'd2);
        wait_idle(cyc);
        check("pchg_gate_len", gate_hi_cnt - g0, 32'd6);
        reg_rd(2'd1, rdat); check("pchg_period", rdat, 32'd2);
        reg_wr(2'd2, 32'h2);

        // Interrupt follows done and drops after W1C
        reg_wr(2'd0, 32'hD);
        check("irq_pre", {31'd0, irq_o}, 32'd0);
        wait_idle(cyc);
        check("lat_p2", cyc, 32'd6);
        check("irq_rise", {31'd0, irq_o}, 32'd1);
        reg_wr(2'd2, 32'h2);
        check("irq_hold_ack", {31'd0, irq_o}, 32'd1);
        @(posedge wb_clk_i);
        #1;
        check("irq_fall", {31'd0, irq_o}, 32'd0);

        // Partial write is acked but has no effect
        wb_xfer(1'b1, BASE, 32'h0, 4'h1, rdat, acked);
        check("partial_ack", {31'd0, acked}, 32'd1);
        reg_rd(2'd0, rdat); check("partial_ctrl", rdat, 32'h9);

        // Asynchronous reset in the middle of a window
        reg_wr(2'd1, 32'd10);
        reg_wr(2'd0, 32'h5);
        repeat (4) @(posedge wb_clk_i);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check("arst_gate",  {31'd0, dp_gate_o}, 32'd0);
        check("arst_busy",  {31'd0, busy_o},    32'd0);
        check("arst_clear", {31'd0, dp_clear_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        reg_rd(2'd0, rdat); check("arst_ctrl",   rdat, 32'd0);
        reg_rd(2'd1, rdat); check("arst_period", rdat, 32'd0);
        reg_rd(2'd3, rdat); check("arst_result", rdat, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
